// File: rtl/cpu_pkg.sv
// Shared pipeline constants and types: register numbering and forward-select
// encodings used by the hazard controller and the register read ports.
package cpu_pkg;
   localparam int REG_NUM_WIDTH     = 4;
   localparam int REG_FORWARD_WIDTH = 2;
   localparam int NUM_REGISTERS     = 1 << REG_NUM_WIDTH;

   typedef logic [REG_NUM_WIDTH-1:0]     reg_num_t;
   typedef logic [REG_FORWARD_WIDTH-1:0] fwd_sel_t;

   localparam fwd_sel_t REG_FORWARD_REG_FILE = 2'b00;
   localparam fwd_sel_t REG_FORWARD_WB       = 2'b01;
   localparam fwd_sel_t REG_FORWARD_R0       = 2'b10;
endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port hazard detection and forward-select computation for the
// instruction in ID against the instruction in EX and the mul/div unit.
module fwd_port_sel
   import cpu_pkg::*;
(
   input  logic     i_en,
   input  reg_num_t i_rs,
   input  reg_num_t i_ex_rd,
   input  logic     i_ex_we,
   input  logic     i_ex_is_load,
   input  logic     i_md_busy,
   input  logic     i_md_start,
   output logic     o_hazard,
   output fwd_sel_t o_sel
);
   logic w_rs_is_r0;
   logic w_ex_match;
   logic w_load_hz;
   logic w_r0_hz;

   assign w_rs_is_r0 = (i_rs == '0);
   assign w_ex_match = i_ex_we && (i_ex_rd == i_rs);

   // A load in EX has no result to forward yet; R0 is owned by the mul/div unit.
   assign w_load_hz = w_ex_match && i_ex_is_load && !w_rs_is_r0;
   assign w_r0_hz   = w_rs_is_r0 && (i_md_busy || i_md_start);
   assign o_hazard  = i_en && (w_load_hz || w_r0_hz);

   always_comb begin
      o_sel = REG_FORWARD_REG_FILE;
      if (i_en) begin
         if (w_rs_is_r0)
            o_sel = REG_FORWARD_R0;
         else if (w_ex_match)
            o_sel = REG_FORWARD_WB;
      end
   end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: ID-vs-EX source/destination compare,
// mul/div busy tracking for R0, stall/bubble generation and error pulse.
module fwd_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int MD_LATENCY = 4,
   parameter int CNT_WIDTH  = 4
)(
   input  logic     clk,
   input  logic     rst,
   input  reg_num_t id_rs_a,
   input  logic     id_rs_a_en,
   input  reg_num_t id_rs_b,
   input  logic     id_rs_b_en,
   input  logic     id_valid,
   input  reg_num_t ex_rd,
   input  logic     ex_we,
   input  logic     ex_is_load,
   input  logic     md_start,
   output fwd_sel_t fwd_a,
   output fwd_sel_t fwd_b,
   output logic     stall,
   output logic     bubble,
   output logic     md_busy,
   output logic     exception
);
   logic [CNT_WIDTH-1:0] r_md_cnt;
   fwd_sel_t             r_fwd_a;
   fwd_sel_t             r_fwd_b;
   logic                 r_bubble;
   logic                 r_exception;

   logic     w_en_a;
   logic     w_en_b;
   logic     w_hz_a;
   logic     w_hz_b;
   fwd_sel_t w_sel_a;
   fwd_sel_t w_sel_b;
   logic     w_md_busy;
   logic     w_exc_next;

   assign w_en_a    = id_valid && id_rs_a_en;
   assign w_en_b    = id_valid && id_rs_b_en;
   assign w_md_busy = (r_md_cnt != '0);

   fwd_port_sel u_port_a (
      .i_en         (w_en_a),
      .i_rs         (id_rs_a),
      .i_ex_rd      (ex_rd),
      .i_ex_we      (ex_we),
      .i_ex_is_load (ex_is_load),
      .i_md_busy    (w_md_busy),
      .i_md_start   (md_start),
      .o_hazard     (w_hz_a),
      .o_sel        (w_sel_a)
   );

   fwd_port_sel u_port_b (
      .i_en         (w_en_b),
      .i_rs         (id_rs_b),
      .i_ex_rd      (ex_rd),
      .i_ex_we      (ex_we),
      .i_ex_is_load (ex_is_load),
      .i_md_busy    (w_md_busy),
      .i_md_start   (md_start),
      .o_hazard     (w_hz_b),
      .o_sel        (w_sel_b)
   );

   // A stray write to R0, or a second mul/div issued while one is in flight.
   assign w_exc_next = (ex_we && (ex_rd == '0) && !md_start) || (md_start && w_md_busy);

   assign stall = rst && (w_hz_a || w_hz_b);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_md_cnt    <= '0;
         r_fwd_a     <= REG_FORWARD_REG_FILE;
         r_fwd_b     <= REG_FORWARD_REG_FILE;
         r_bubble    <= 1'b0;
         r_exception <= 1'b0;
      end else begin
         if (md_start && !w_md_busy)
            r_md_cnt <= CNT_WIDTH'(MD_LATENCY);
         else if (w_md_busy)
            r_md_cnt <= r_md_cnt - 1'b1;

         if (stall) begin
            r_fwd_a <= REG_FORWARD_REG_FILE;
            r_fwd_b <= REG_FORWARD_REG_FILE;
         end else begin
            r_fwd_a <= w_sel_a;
            r_fwd_b <= w_sel_b;
         end
         r_bubble    <= stall;
         r_exception <= w_exc_next;
      end
   end

   assign fwd_a     = r_fwd_a;
   assign fwd_b     = r_fwd_b;
   assign bubble    = r_bubble;
   assign md_busy   = w_md_busy;
   assign exception = r_exception;
endmodule
